// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC with seq/branch/jump/call/ret and return stack; in clk rst stall op cond offset target, out pc depth ovf unf flush
module pc_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic [2:0]                 op,
  input  logic                       cond,
  input  logic [WIDTH-1:0]           offset,
  input  logic [WIDTH-1:0]           target,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       ovf,
  output logic                       unf,
  output logic                       flush
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] pc_inc, pc_next, top;
  logic [DW-1:0] depth_next;
  logic full, empty, br_taken, is_jmp, is_call, is_ret, push, pop, redirect;
  assign pc_inc = pc + WIDTH'(1);
  assign full = depth == DW'(DEPTH);
  assign empty = depth == '0;
  assign top = stack[AW'(depth - DW'(1))];
  assign br_taken = op == 3'b001 && cond;
  assign is_jmp = op == 3'b010;
  assign is_call = op == 3'b011;
  assign is_ret = op == 3'b100;
  assign push = is_call && !full;
  assign pop = is_ret && !empty;
  assign redirect = br_taken || is_jmp || is_call || pop;
  always_comb begin
    pc_next = br_taken ? pc + offset : (is_jmp || is_call) ? target : pop ? top : pc_inc;
    depth_next = push ? depth + DW'(1) : pop ? depth - DW'(1) : depth;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
      depth <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      flush <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (stall) begin
      flush <= 1'b0;
    end else begin
      pc <= pc_next;
      depth <= depth_next;
      ovf <= ovf | (is_call && full);
      unf <= unf | (is_ret && empty);
      flush <= redirect;
      if (push) stack[depth[AW-1:0]] <= pc_inc;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench comparing pc_sequencer against a queue-based return-stack model
module tb_pc_sequencer;
  localparam logic [15:0] RV = 16'h0100;
  logic clk = 1'b0, rst = 1'b0, stall = 1'b0, cond = 1'b0;
  logic [2:0] op = '0;
  logic [15:0] offset = '0, target = '0, pc;
  logic [2:0] depth;
  logic ovf, unf, flush;
  int checks = 0, errors = 0;
  typedef struct {
    logic [15:0] pc;
    logic [2:0] depth;
    logic ovf, unf, flush;
  } exp_t;
  exp_t exp_q[$];
  logic [15:0] m_pc = RV;
  logic [15:0] m_stk[$];
  logic m_ovf = 1'b0, m_unf = 1'b0, m_flush = 1'b0;

  pc_sequencer #(.WIDTH(16), .DEPTH(4), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .cond(cond), .offset(offset),
    .target(target), .pc(pc), .depth(depth), .ovf(ovf), .unf(unf), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("depth", 16'(depth), 16'(e.depth));
      chk("ovf", 16'(ovf), 16'(e.ovf));
      chk("unf", 16'(unf), 16'(e.unf));
      chk("flush", 16'(flush), 16'(e.flush));
    end
  end

  task automatic step(input logic r, input logic s, input logic [2:0] o, input logic c,
                      input logic [15:0] off, input logic [15:0] tgt);
    @(negedge clk);
    rst = r; stall = s; op = o; cond = c; offset = off; target = tgt;
    if (r) begin
      m_pc = RV; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_flush = 1'b0;
    end else if (s) begin
      m_flush = 1'b0;
    end else begin
      m_flush = 1'b0;
      case (o)
        3'd1: if (c) begin m_pc = m_pc + off; m_flush = 1'b1; end else m_pc = m_pc + 16'd1;
        3'd2: begin m_pc = tgt; m_flush = 1'b1; end
        3'd3: begin
          if (m_stk.size() < 4) m_stk.push_back(m_pc + 16'd1); else m_ovf = 1'b1;
          m_pc = tgt; m_flush = 1'b1;
        end
        3'd4: if (m_stk.size() > 0) begin m_pc = m_stk.pop_back(); m_flush = 1'b1; end
              else begin m_unf = 1'b1; m_pc = m_pc + 16'd1; end
        default: m_pc = m_pc + 16'd1;
      endcase
    end
    exp_q.push_back('{m_pc, 3'(m_stk.size()), m_ovf, m_unf, m_flush});
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 3'd0, 0, 0, 0);
    step(0, 0, 3'd2, 0, 0, 16'h0010);
    step(0, 0, 3'd1, 1, 16'hFFF8, 0);
    step(0, 0, 3'd2, 0, 0, 16'h0010);
    step(0, 0, 3'd1, 0, 16'hFFF8, 0);
    step(0, 0, 3'd2, 0, 0, 16'hFFFF);
    step(0, 0, 3'd0, 0, 0, 0);
    step(0, 0, 3'd2, 0, 0, 16'h1234);
    step(0, 0, 3'd2, 0, 0, 16'h0020);
    for (int i = 1; i <= 5; i++) step(0, 0, 3'd3, 0, 0, 16'(i * 16'h0100));
    repeat (5) step(0, 0, 3'd4, 0, 0, 0);
    step(0, 0, 3'd3, 0, 0, 16'h0700);
    repeat (3) step(0, 1, 3'd2, 0, 0, 16'hBEEF);
    step(0, 0, 3'd3, 0, 0, 16'h0800);
    step(1, 1, 3'd2, 1, 16'h5555, 16'hAAAA);
    repeat (3) step(0, 0, 3'd5 + 3'($urandom_range(0, 2)), 0, 0, 0);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)),
           1'($urandom), 16'($urandom), 16'($urandom));
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
